// File: rtl/motor_drive_ctrl.sv
// H-bridge drive for two DC wheel motors: steering command to direction pins + PWM enables,
// with coast dead-time on wheel reversal. Define DRIVE_RAMP_EN to soft-ramp duty increases.
module motor_drive_ctrl #(
    parameter int unsigned PWM_BITS    = 10,
    parameter int unsigned CRUISE_DUTY = 700,
    parameter int unsigned TURN_DUTY   = 450,
    parameter int unsigned DEADTIME    = 64,
    parameter int unsigned RAMP_STEP   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] state,
    output logic [1:0] left_in,
    output logic [1:0] right_in,
    output logic       left_pwm,
    output logic       right_pwm,
    output logic [1:0] cur_cmd
);

    localparam logic [1:0] CmdLeft     = 2'b00;
    localparam logic [1:0] CmdRight    = 2'b01;
    localparam logic [1:0] CmdStraight = 2'b10;
    localparam logic [1:0] CmdStop     = 2'b11;

    localparam int unsigned DutyMax = (1 << PWM_BITS) - 1;
    localparam logic [PWM_BITS-1:0] CruiseSat =
        PWM_BITS'((CRUISE_DUTY > DutyMax) ? DutyMax : CRUISE_DUTY);
    localparam logic [PWM_BITS-1:0] TurnSat =
        PWM_BITS'((TURN_DUTY > DutyMax) ? DutyMax : TURN_DUTY);

    localparam int unsigned DtW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
    localparam logic [DtW-1:0] DtLoad = DtW'(DEADTIME - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDead} st_e;

    st_e                 st_q, st_d;
    logic [1:0]          cmd_q, cmd_d;
    logic [1:0]          cur_q, cur_d;
    logic [DtW-1:0]      dt_q, dt_d;
    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [PWM_BITS-1:0] duty_tgt;
    logic                zero_duty;
    logic                pwm_on;

    function automatic logic [1:0] left_pins(input logic [1:0] cmd);
        unique case (cmd)
            CmdLeft:     left_pins = 2'b01;
            CmdRight:    left_pins = 2'b10;
            CmdStraight: left_pins = 2'b10;
            default:     left_pins = 2'b11;
        endcase
    endfunction

    function automatic logic [1:0] right_pins(input logic [1:0] cmd);
        unique case (cmd)
            CmdLeft:     right_pins = 2'b10;
            CmdRight:    right_pins = 2'b01;
            CmdStraight: right_pins = 2'b10;
            default:     right_pins = 2'b11;
        endcase
    endfunction

    function automatic logic is_rev(input logic [1:0] a, input logic [1:0] b);
        is_rev = ((a == 2'b10) && (b == 2'b01)) || ((a == 2'b01) && (b == 2'b10));
    endfunction

    function automatic logic [PWM_BITS-1:0] cmd_duty(input logic [1:0] cmd);
        unique case (cmd)
            CmdLeft, CmdRight: cmd_duty = TurnSat;
            CmdStraight:       cmd_duty = CruiseSat;
            default:           cmd_duty = '0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q   <= StIdle;
            cmd_q  <= CmdStop;
            cur_q  <= CmdStop;
            dt_q   <= '0;
            cnt_q  <= '0;
            duty_q <= '0;
        end else begin
            st_q   <= st_d;
            cmd_q  <= cmd_d;
            cur_q  <= cur_d;
            dt_q   <= dt_d;
            cnt_q  <= cnt_d;
            duty_q <= duty_d;
        end
    end

    // cmd_q always holds the newest command, so it doubles as the latched DEAD target.
    always_comb begin
        st_d      = st_q;
        cmd_d     = state;
        cur_d     = cur_q;
        dt_d      = dt_q;
        zero_duty = 1'b0;
        unique case (st_q)
            StIdle: begin
                st_d  = StRun;
                cur_d = state;
            end
            StRun: begin
                if (cmd_q != cur_q) begin
                    if (is_rev(left_pins(cur_q), left_pins(cmd_q)) ||
                        is_rev(right_pins(cur_q), right_pins(cmd_q))) begin
                        st_d      = StDead;
                        dt_d      = DtLoad;
                        zero_duty = 1'b1;
                    end else begin
                        cur_d     = cmd_q;
                        zero_duty = (cmd_q == CmdStop);
                    end
                end
            end
            StDead: begin
                zero_duty = 1'b1;
                if (cmd_q == CmdStop) begin
                    st_d  = StRun;
                    cur_d = CmdStop;
                end else if (dt_q == '0) begin
                    st_d  = StRun;
                    cur_d = cmd_q;
                end else begin
                    dt_d = dt_q - 1'b1;
                end
            end
            default: st_d = StIdle;
        endcase
    end

    assign duty_tgt = (st_q == StRun) ? cmd_duty(cur_q) : '0;

`ifdef DRIVE_RAMP_EN
    logic [PWM_BITS:0] ramp_sum;
    assign ramp_sum = {1'b0, duty_q} + (PWM_BITS + 1)'(RAMP_STEP);
`endif

    // Duty only changes at wrap so a period is never cut short, except forced-zero events.
    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        duty_d = duty_q;
        if (cnt_q == '1) begin
`ifdef DRIVE_RAMP_EN
            if ((duty_tgt <= duty_q) || (ramp_sum >= {1'b0, duty_tgt})) begin
                duty_d = duty_tgt;
            end else begin
                duty_d = ramp_sum[PWM_BITS-1:0];
            end
`else
            duty_d = duty_tgt;
`endif
        end
        if (zero_duty) begin
            duty_d = '0;
        end
    end

    assign pwm_on = (st_q == StRun) && (cnt_q < duty_q);

    always_comb begin
        left_in  = 2'b00;
        right_in = 2'b00;
        if (st_q == StRun) begin
            left_in  = left_pins(cur_q);
            right_in = right_pins(cur_q);
        end
    end

    assign left_pwm  = pwm_on;
    assign right_pwm = pwm_on;
    assign cur_cmd   = cur_q;

endmodule

// File: doc/motor_drive_ctrl.md
# motor_drive_ctrl

Downstream consumer of the line-tracker policy stage. Takes the registered 2-bit steering command and drives the two DC wheel motors through an H-bridge. It generates per-wheel direction pins and PWM enables. It inserts a coast dead-time on any wheel reversal and, optionally, soft-ramps duty.

## Interface
- PWM_BITS, 10, PWM counter width; period = 2^PWM_BITS cycles
- CRUISE_DUTY, 700, duty (counts) for go_straight, both wheels
- TURN_DUTY, 450, duty for pivot turns, both wheels
- DEADTIME, 64, coast cycles inserted on forward<->reverse change of any wheel (≥1)
- RAMP_STEP, 16, duty increment per PWM period when ramp compiled in
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- state  in  2  command: 00 turn_left, 01 turn_right, 10 go_straight, 11 stop
- left_in  out  2  left H-bridge IN1/IN2: 10 fwd, 01 rev, 00 coast, 11 brake
- right_in  out  2  right H-bridge, same encoding
- left_pwm  out  1  left enable PWM
- right_pwm  out  1  right enable PWM
- cur_cmd  out  2  command currently applied to pins (same encoding as state)

## Operation
- Command map:
  - turn_left: left rev, right fwd, TURN_DUTY.
  - turn_right: left fwd, right rev, TURN_DUTY.
  - go_straight: both fwd, CRUISE_DUTY.
  - stop: both brake (11), duty 0.
- FSM states:
  - IDLE: after reset; pins coast, duty 0. Leaves on first clock, loading the sampled command into RUN with no dead-time.
  - RUN: pins follow cur_cmd. An input differing from cur_cmd is handled as follows:
    - If any wheel goes fwd<->rev, enter DEAD and latch the target.
    - Otherwise update pins/cur_cmd directly and stay in RUN.
  - DEAD: all in = 00, pwm low, duty_cur forced 0. Down-counter runs DEADTIME cycles, then RUN with the latest latched target.
    - A non-stop command during DEAD overwrites the target without restarting the counter.
    - stop during DEAD aborts immediately to RUN with brake.
- stop always applies immediately from any state: brake pins, duty_cur = 0, no dead-time.
- Brake/coast -> fwd or rev never triggers dead-time.
- PWM: free-running PWM_BITS counter, wraps max->0. pwm = (cnt < duty_cur). duty 0 gives constant low.
- duty_cur loads from target only at wrap (cnt == max), so there are no mid-period glitches. The exceptions are stop and DEAD entry, which zero duty_cur at once.
- Duties are unsigned PWM_BITS. Targets above 2^PWM_BITS-1 are clamped to max.

## Timing
- Reset values: left_in = right_in = 00, left_pwm = right_pwm = 0, cur_cmd = 11, FSM IDLE, cnt 0, duty_cur 0.
- The input is registered. A change sampled at edge N updates in/cur_cmd at edge N+1 (no reversal) or enters DEAD at N+1.
- DEAD holds pins at 00 for exactly DEADTIME cycles. New direction pins appear on the next edge.
- New duty takes effect at the first wrap after the pins update. Worst-case latency to PWM is 2^PWM_BITS+1 cycles.
- stop: brake pins and pwm low at edge N+1.
- Reset asserted mid-DEAD or mid-period returns all outputs to reset values on the next edge.

## Configuration
- DRIVE_RAMP_EN defined: at each wrap, duty_cur steps toward target by RAMP_STEP, saturating at target.
  - Decreases apply at once, not ramped.
  - After DEAD or stop, the ramp restarts from 0.
- DRIVE_RAMP_EN undefined: duty_cur = target at the next wrap.

## Test plan
- Reset, then hold state = 10: at cycle 1, left_in = right_in = 10 and cur_cmd = 10. From the first wrap (cnt 0), pwm is high for 700 of 1024 cycles (no ramp).
- 10 -> 00: left_in = right_in = 00 for exactly 64 cycles, then left_in = 01, right_in = 10. Duty becomes 450 at the next wrap.
- 00 -> 01 during DEAD, 20 cycles into a 10 -> 00 change: DEAD ends at cycle 64 and the pins show turn_right (10/01).
- 10 -> 11 mid-period: next edge gives both in = 11, pwm = 0, no dead-time. Then 11 -> 10 gives fwd pins next edge with no DEAD.
- With DRIVE_RAMP_EN defined, reset and hold 10: duty_cur is 16, 32, … per period and saturates at 700 after 44 periods.
- Reset asserted in DEAD: next edge all in = 00, pwm = 0, cur_cmd = 11.
